// File: rtl/path_walker.sv
// Walks a planner edge list backwards through the shared edge RAM and streams the
// resulting pose chain (startPose .. endPose) over a valid/ready handshake.
//   state | meaning
//   IDLE  | waiting for start
//   EMIT  | pose_out valid, waiting for handshake
//   FETCH | drive RAM address for the next edge
//   WAIT  | RAM read latency
//   CHECK | resolve next pose from the edge's pose pair
//   DONE  | one-cycle done pulse
//   ERR   | raise sticky error, return to IDLE
module path_walker #(
    parameter int MAX_EDGE = 10,
    parameter int EDGE_W   = 11,
    parameter int POSE_W   = 8,
    parameter int EDGE_NUM = 1034
) (
    input  logic                         CLK,
    input  logic                         RST_n,
    input  logic                         start,
    input  logic [3:0]                   pathLen,
    input  logic [MAX_EDGE*EDGE_W-1:0]   selectEdge,
    input  logic [POSE_W-1:0]            startPose,
    input  logic [POSE_W-1:0]            endPose,
    output logic [EDGE_W-1:0]            ramAddress,
    input  logic [2*POSE_W-1:0]          RAMData,
    output logic [POSE_W-1:0]            pose_out,
    output logic                         pose_valid,
    input  logic                         pose_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [1:0]                   errCode
);

    typedef enum logic [2:0] {
        IDLE, EMIT, FETCH, WAIT, CHECK, DONE, ERR
    } state_t;

    state_t                       state_q, state_d;
    logic [MAX_EDGE*EDGE_W-1:0]   sel_edge_q, sel_edge_d;
    logic [3:0]                   idx_q, idx_d;
    logic [3:0]                   left_q, left_d;
    logic [POSE_W-1:0]            end_q, end_d;
    logic [POSE_W-1:0]            pose_out_q, pose_out_d;
    logic                         pose_valid_q, pose_valid_d;
    logic [EDGE_W-1:0]            ram_addr_q, ram_addr_d;
    logic                         busy_q, busy_d;
    logic                         error_q, error_d;
    logic [1:0]                   err_code_q, err_code_d;

    logic [EDGE_W-1:0]            edge_sel;
    logic [POSE_W-1:0]            first_pose;
    logic [POSE_W-1:0]            second_pose;

    assign edge_sel    = sel_edge_q[idx_q*EDGE_W +: EDGE_W];
    assign first_pose  = RAMData[2*POSE_W-1:POSE_W];
    assign second_pose = RAMData[POSE_W-1:0];

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q      <= IDLE;
            sel_edge_q   <= '0;
            idx_q        <= '0;
            left_q       <= '0;
            end_q        <= '0;
            pose_out_q   <= '0;
            pose_valid_q <= 1'b0;
            ram_addr_q   <= '0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            sel_edge_q   <= sel_edge_d;
            idx_q        <= idx_d;
            left_q       <= left_d;
            end_q        <= end_d;
            pose_out_q   <= pose_out_d;
            pose_valid_q <= pose_valid_d;
            ram_addr_q   <= ram_addr_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_edge_d   = sel_edge_q;
        idx_d        = idx_q;
        left_d       = left_q;
        end_d        = end_q;
        pose_out_d   = pose_out_q;
        pose_valid_d = pose_valid_q;
        ram_addr_d   = ram_addr_q;
        busy_d       = busy_q;
        error_d      = error_q;
        err_code_d   = err_code_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_edge_d = selectEdge;
                    end_d      = endPose;
                    error_d    = 1'b0;
                    err_code_d = 2'd0;
                    busy_d     = 1'b1;
                    if (pathLen == 4'd0 || pathLen > 4'(MAX_EDGE)) begin
                        err_code_d = 2'd1;
                        state_d    = ERR;
                    end else begin
                        pose_out_d   = startPose;
                        idx_d        = pathLen - 4'd1;
                        left_d       = pathLen;
                        pose_valid_d = 1'b1;
                        state_d      = EMIT;
                    end
                end
            end
            EMIT: begin
                if (pose_ready) begin
                    pose_valid_d = 1'b0;
                    if (left_q == 4'd0) begin
                        if (pose_out_q == end_q) begin
                            state_d = DONE;
                        end else begin
                            err_code_d = 2'd3;
                            state_d    = ERR;
                        end
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                // An illegal index never reaches the RAM address bus.
                if (edge_sel >= EDGE_W'(EDGE_NUM)) begin
                    err_code_d = 2'd2;
                    state_d    = ERR;
                end else begin
                    ram_addr_d = edge_sel;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (first_pose == pose_out_q && second_pose != pose_out_q) begin
                    pose_out_d   = second_pose;
                    idx_d        = idx_q - 4'd1;
                    left_d       = left_q - 4'd1;
                    pose_valid_d = 1'b1;
                    state_d      = EMIT;
                end else if (second_pose == pose_out_q && first_pose != pose_out_q) begin
                    pose_out_d   = first_pose;
                    idx_d        = idx_q - 4'd1;
                    left_d       = left_q - 4'd1;
                    pose_valid_d = 1'b1;
                    state_d      = EMIT;
                end else begin
                    err_code_d = 2'd3;
                    state_d    = ERR;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            ERR: begin
                error_d      = 1'b1;
                busy_d       = 1'b0;
                pose_valid_d = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ramAddress = ram_addr_q;
    assign pose_out   = pose_out_q;
    assign pose_valid = pose_valid_q;
    assign busy       = busy_q;
    assign done       = (state_q == DONE);
    assign error      = error_q;
    assign errCode    = err_code_q;

endmodule

// File: tb/tb_path_walker.sv
// Scoreboard bench for path_walker: expected poses are queued at stimulus time and
// popped by a monitor on every accepted handshake.
module tb_path_walker;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  pathLen = 4'd0;
    logic [109:0] selectEdge = '0;
    logic [7:0]  startPose = 8'd0;
    logic [7:0]  endPose = 8'd0;
    logic [10:0] ramAddress;
    logic [15:0] RAMData;
    logic [7:0]  pose_out;
    logic        pose_valid;
    logic        pose_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  errCode;

    path_walker dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .pathLen(pathLen),
        .selectEdge(selectEdge), .startPose(startPose), .endPose(endPose),
        .ramAddress(ramAddress), .RAMData(RAMData), .pose_out(pose_out),
        .pose_valid(pose_valid), .pose_ready(pose_ready), .busy(busy),
        .done(done), .error(error), .errCode(errCode)
    );

    always #5 CLK = ~CLK;

    logic [15:0] ram [0:2047];
    always @(posedge CLK) RAMData <= ram[ramAddress];

    int          tests_run = 0;
    int          failed = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    int          pose_cnt = 0;
    int          done_cnt = 0;
    int          valid_cycles = 0;
    bit          addr_bad = 1'b0;

    // Handshake monitor: handshake seen at negedge completes on the following posedge.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST_n) begin
                if (pose_valid) valid_cycles++;
                if (done) done_cnt++;
                if (ramAddress >= 11'd1034) addr_bad = 1'b1;
                if (pose_valid && pose_ready) begin
                    pose_cnt++;
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        failed++;
                        $display("FAIL pose_unexpected got=%0d expected=none", pose_out);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (pose_out !== mon_exp) begin
                            failed++;
                            $display("FAIL pose_value got=%0d expected=%0d", pose_out, mon_exp);
                        end
                    end
                end
            end
        end
    end

    task automatic setup_walk(input logic [3:0] plen, input logic [10:0] s0, input logic [10:0] s1,
                              input logic [7:0] sp, input logic [7:0] ep);
        selectEdge         = '1;
        selectEdge[10:0]   = s0;
        selectEdge[21:11]  = s1;
        pathLen            = plen;
        startPose          = sp;
        endPose            = ep;
        pose_cnt           = 0;
        done_cnt           = 0;
        valid_cycles       = 0;
        addr_bad           = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (!busy) begin
                timed_out = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        tests_run++;
        if ({ramAddress, pose_out, pose_valid, busy, done, error, errCode} !== 36'd0) begin
            failed++;
            $display("FAIL reset_outputs got=%h expected=0",
                     {ramAddress, pose_out, pose_valid, busy, done, error, errCode});
        end
        @(posedge CLK); #1 RST_n = 1'b1;
    endtask

    task automatic test_basic();
        bit to;
        ram[5]  = 16'h0703;
        ram[12] = 16'h0107;
        pose_ready = 1'b1;
        setup_walk(4'd2, 11'd5, 11'd12, 8'd1, 8'd3);
        exp_q.push_back(8'd1); exp_q.push_back(8'd7); exp_q.push_back(8'd3);
        pulse_start();
        @(negedge CLK);
        tests_run++;
        if (pose_valid !== 1'b1 || pose_out !== 8'd1) begin
            failed++;
            $display("FAIL basic_first_latency got valid=%b pose=%0d expected valid=1 pose=1", pose_valid, pose_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            tests_run++;
            if (pose_valid !== 1'b0) begin
                failed++;
                $display("FAIL basic_gap got valid=%b expected 0 (cycle %0d)", pose_valid, i);
            end
        end
        @(negedge CLK);
        tests_run++;
        if (pose_valid !== 1'b1 || pose_out !== 8'd7) begin
            failed++;
            $display("FAIL basic_second_latency got valid=%b pose=%0d expected valid=1 pose=7", pose_valid, pose_out);
        end
        wait_idle(to);
        tests_run++;
        if (to || exp_q.size() != 0 || pose_cnt != 3) begin
            failed++;
            $display("FAIL basic_stream got timeout=%0d left=%0d poses=%0d expected 0/0/3", to, exp_q.size(), pose_cnt);
        end
        tests_run++;
        if (done_cnt != 1 || error !== 1'b0 || errCode !== 2'd0) begin
            failed++;
            $display("FAIL basic_status got done=%0d err=%b code=%0d expected 1/0/0", done_cnt, error, errCode);
        end
    endtask

    task automatic test_stall();
        bit to;
        ram[5]  = 16'h0703;
        ram[12] = 16'h0107;
        pose_ready = 1'b1;
        setup_walk(4'd2, 11'd5, 11'd12, 8'd1, 8'd3);
        exp_q.push_back(8'd1); exp_q.push_back(8'd7); exp_q.push_back(8'd3);
        pulse_start();
        @(posedge CLK); #1 pose_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (pose_valid) break;
        end
        tests_run++;
        if (pose_valid !== 1'b1) begin
            failed++;
            $display("FAIL stall_wait got valid=%b expected 1", pose_valid);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            tests_run++;
            if (pose_valid !== 1'b1 || pose_out !== 8'd7) begin
                failed++;
                $display("FAIL stall_hold got valid=%b pose=%0d expected valid=1 pose=7", pose_valid, pose_out);
            end
        end
        @(posedge CLK); #1 pose_ready = 1'b1;
        wait_idle(to);
        tests_run++;
        if (to || exp_q.size() != 0 || pose_cnt != 3 || done_cnt != 1) begin
            failed++;
            $display("FAIL stall_stream got timeout=%0d left=%0d poses=%0d done=%0d expected 0/0/3/1",
                     to, exp_q.size(), pose_cnt, done_cnt);
        end
    endtask

    task automatic test_bad_len();
        bit to;
        logic [3:0] lens [2];
        lens[0] = 4'd0;
        lens[1] = 4'd11;
        for (int k = 0; k < 2; k++) begin
            setup_walk(lens[k], 11'd5, 11'd12, 8'd1, 8'd3);
            pulse_start();
            wait_idle(to);
            tests_run++;
            if (to || error !== 1'b1 || errCode !== 2'd1 || busy !== 1'b0 || valid_cycles != 0) begin
                failed++;
                $display("FAIL bad_len len=%0d got timeout=%0d err=%b code=%0d busy=%b valid_cycles=%0d expected 0/1/1/0/0",
                         lens[k], to, error, errCode, busy, valid_cycles);
            end
        end
    endtask

    task automatic test_bad_index();
        bit to;
        setup_walk(4'd1, 11'd1040, 11'd12, 8'd1, 8'd3);
        exp_q.push_back(8'd1);
        pulse_start();
        wait_idle(to);
        tests_run++;
        if (to || error !== 1'b1 || errCode !== 2'd2) begin
            failed++;
            $display("FAIL bad_index_code got timeout=%0d err=%b code=%0d expected 0/1/2", to, error, errCode);
        end
        tests_run++;
        if (exp_q.size() != 0 || pose_cnt != 1 || addr_bad || done_cnt != 0) begin
            failed++;
            $display("FAIL bad_index_stream got left=%0d poses=%0d addr_bad=%0d done=%0d expected 0/1/0/0",
                     exp_q.size(), pose_cnt, addr_bad, done_cnt);
        end
    endtask

    task automatic test_chain_err();
        bit to;
        ram[12] = 16'h0409;
        ram[20] = 16'h0101;
        for (int k = 0; k < 2; k++) begin
            setup_walk(4'd1, (k == 0) ? 11'd12 : 11'd20, 11'd0, 8'd1, 8'd9);
            exp_q.push_back(8'd1);
            pulse_start();
            wait_idle(to);
            tests_run++;
            if (to || error !== 1'b1 || errCode !== 2'd3 || exp_q.size() != 0 || done_cnt != 0) begin
                failed++;
                $display("FAIL chain_broken case=%0d got timeout=%0d err=%b code=%0d left=%0d done=%0d expected 0/1/3/0/0",
                         k, to, error, errCode, exp_q.size(), done_cnt);
            end
        end
        ram[5]  = 16'h0703;
        ram[12] = 16'h0107;
        setup_walk(4'd2, 11'd5, 11'd12, 8'd1, 8'd4);
        exp_q.push_back(8'd1); exp_q.push_back(8'd7); exp_q.push_back(8'd3);
        pulse_start();
        wait_idle(to);
        tests_run++;
        if (to || error !== 1'b1 || errCode !== 2'd3 || exp_q.size() != 0 || done_cnt != 0) begin
            failed++;
            $display("FAIL chain_end_mismatch got timeout=%0d err=%b code=%0d left=%0d done=%0d expected 0/1/3/0/0",
                     to, error, errCode, exp_q.size(), done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        ram[5]  = 16'h0703;
        ram[12] = 16'h0107;
        pose_ready = 1'b1;
        setup_walk(4'd2, 11'd5, 11'd12, 8'd1, 8'd3);
        exp_q.push_back(8'd1); exp_q.push_back(8'd7); exp_q.push_back(8'd3);
        pulse_start();
        @(posedge CLK); #1 RST_n = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        tests_run++;
        if ({ramAddress, pose_out, pose_valid, busy, done, error, errCode} !== 36'd0) begin
            failed++;
            $display("FAIL reset_mid_outputs got=%h expected=0",
                     {ramAddress, pose_out, pose_valid, busy, done, error, errCode});
        end
        @(posedge CLK); #1 RST_n = 1'b1;
        setup_walk(4'd2, 11'd5, 11'd12, 8'd1, 8'd3);
        repeat (10) @(negedge CLK);
        tests_run++;
        if (pose_cnt != 0 || valid_cycles != 0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_quiet got poses=%0d valid_cycles=%0d busy=%b expected 0/0/0",
                     pose_cnt, valid_cycles, busy);
        end
    endtask

    task automatic test_start_busy();
        bit to;
        ram[5]  = 16'h0703;
        ram[12] = 16'h0107;
        pose_ready = 1'b1;
        setup_walk(4'd2, 11'd5, 11'd12, 8'd1, 8'd3);
        exp_q.push_back(8'd1); exp_q.push_back(8'd7); exp_q.push_back(8'd3);
        pulse_start();
        repeat (2) @(posedge CLK);
        #1;
        pathLen   = 4'd0;
        startPose = 8'd9;
        pulse_start();
        wait_idle(to);
        tests_run++;
        if (to || exp_q.size() != 0 || pose_cnt != 3 || done_cnt != 1 || error !== 1'b0) begin
            failed++;
            $display("FAIL start_busy got timeout=%0d left=%0d poses=%0d done=%0d err=%b expected 0/0/3/1/0",
                     to, exp_q.size(), pose_cnt, done_cnt, error);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 16'h0000;
        test_reset();
        test_basic();
        test_stall();
        test_bad_len();
        test_bad_index();
        test_chain_err();
        test_reset_mid();
        test_basic();
        test_start_busy();
        repeat (2) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
